hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised next-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W). It generates stall, flush and forwarding controls for the ALU operands in E and for branch compares in D. Over a purely combinational hazard unit, it adds configurable register-address width, a registered multi-cycle mul/div busy timer that stalls HI/LO consumers, and zero-register-safe forwarding on both E operands.

Parameters:
REG_AW, 5, register-address width in bits.
MD_LATENCY, 32, cycles the mul/div unit is busy after issue; legal range 1..255.
STALL_CNT_W, 32, width of the optional performance counters.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
BranchD  in  1  D-stage instruction is a branch.
MdOpD  in  1  D-stage instruction issues mul/div or reads HI/LO (mult, div, mfhi, mflo).
RsD, RtD  in  REG_AW  D-stage source registers.
RsE, RtE  in  REG_AW  E-stage source registers.
WriteRegE  in  REG_AW  E-stage destination register.
MemtoRegE, RegWriteE  in  1  E-stage is a load / writes the register file.
MdStartE  in  1  mul/div instruction is in E this cycle.
WriteRegM  in  REG_AW  M-stage destination register.
MemtoRegM, RegWriteM  in  1  M-stage controls.
WriteRegW  in  REG_AW  W-stage destination register.
RegWriteW  in  1  W-stage writes the register file.
StallF, StallD, FlushE  out  1  pipeline control.
ForwardAD, ForwardBD  out  1  forward M-stage ALU result to the D-stage comparator.
ForwardAE, ForwardBE  out  2  E operand select: 00 register file, 01 W result, 10 M result.
MdBusy  out  1  mul/div timer is non-zero.

Behaviour:
- ForwardAE: 10 if RsE!=0 && RsE==WriteRegM && RegWriteM.
  - Otherwise 01 if RsE!=0 && RsE==WriteRegW && RegWriteW.
  - Otherwise 00.
  - M has priority over W.
- ForwardBE: same rules using RtE.
- ForwardAD = RsD!=0 && RsD==WriteRegM && RegWriteM. ForwardBD: same using RtD.
- lwstall = MemtoRegE && RtE!=0 && (RtE==RsD || RtE==RtD).
- branchstall = BranchD && the first or second condition below:
  - RegWriteE && WriteRegE!=0 && WriteRegE∈{RsD,RtD};
  - MemtoRegM && WriteRegM!=0 && WriteRegM∈{RsD,RtD}.
- mdstall = MdOpD && MdBusy.
- StallF = StallD = FlushE = lwstall | branchstall | mdstall. These are combinational, with zero latency.
- Mul/div timer: unsigned counter, width $clog2(MD_LATENCY+1).
  - On a rising edge with MdStartE=1: counter <= MD_LATENCY. A restart while busy reloads the counter.
  - Otherwise, if counter!=0: counter <= counter-1.
  - MdBusy = (counter!=0). It asserts the cycle after issue and stays high for exactly MD_LATENCY cycles.
- Boundary cases:
  - MdStartE and counter==1 on the same edge: reload wins.
  - MD_LATENCY=1: busy for one cycle.
  - Counter never wraps below 0.
- Reset: rst asynchronously clears the counter (and perf counters), so MdBusy=0 immediately, including mid-operation. All outputs are then pure functions of the inputs.
- Elaboration error if MD_LATENCY<1 or MD_LATENCY>255.

Optional Feature:
HAZARD_PERF_EN:
- When defined, adds output ports LwStallCnt, BrStallCnt and MdStallCnt, each STALL_CNT_W wide.
- Each counter increments on every rising edge where its stall term is 1, saturates at all-ones, and is cleared by rst.
- Several terms active in one cycle increment every matching counter.
- When undefined: no ports, no registers, functionally identical otherwise.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - constant REG_ZERO;
  - the MD_LATENCY range limits.
- One sub-module, md_busy_timer, contains the reload/decrement counter and MdBusy. Stall and forward logic stays in hazard_ctrl.

Test Plan:
- Forwarding priority: RsE=RtE=3, WriteRegM=WriteRegW=3, RegWriteM=RegWriteW=1 -> ForwardAE=ForwardBE=10. Drop RegWriteM -> 01. Then set RsE=0 -> ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1. Set RtE=0 -> all 0.
- Branch: BranchD=1, RegWriteE=1, WriteRegE=4, RtD=4 -> stall. Next cycle, with the producer in M as ALU op (MemtoRegM=0, RegWriteM=1, WriteRegM=4) -> no stall, ForwardBD=1.
- Mul/div, MD_LATENCY=4: pulse MdStartE at edge 0 -> MdBusy high on edges 1..4, low after edge 4. MdOpD=1 during busy -> stall; stall releases the cycle MdBusy falls.
- Reset mid-operation: rst pulsed asynchronously two cycles after MdStartE -> MdBusy=0 before the next clock edge. Perf counters (if HAZARD_PERF_EN) read 0.
- HAZARD_PERF_EN with STALL_CNT_W=2: hold lwstall for 5 cycles -> LwStallCnt=3 (saturated), BrStallCnt=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and limits for the hazard unit.
package hazard_pkg;
   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;
   localparam int REG_ZERO   = 0;
   localparam int MD_LAT_MIN = 1;
   localparam int MD_LAT_MAX = 255;
   function automatic fwd_sel_t fwd_sel(input logic hit_m, input logic hit_w);
      return hit_m ? FWD_M : hit_w ? FWD_W : FWD_RF;
   endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard unit control and status bundle.
interface hazard_ctrl_if #(parameter int REG_AW = 5);
   logic              BranchD, MdOpD;
   logic [REG_AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic              MemtoRegE, RegWriteE, MdStartE, MemtoRegM, RegWriteM, RegWriteW;
   logic              StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
   logic [1:0]        ForwardAE, ForwardBE;
   modport master (
      output BranchD, MdOpD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             MemtoRegE, RegWriteE, MdStartE, MemtoRegM, RegWriteM, RegWriteW,
      input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy
   );
   modport slave (
      input  BranchD, MdOpD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             MemtoRegE, RegWriteE, MdStartE, MemtoRegM, RegWriteM, RegWriteW,
      output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy
   );
endinterface

// File: rtl/hazard_ctrl_md_busy_timer.sv
// md_busy_timer: reload/decrement counter tracking mul/div occupancy.
module md_busy_timer import hazard_pkg::*; #(
   parameter int MD_LATENCY = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy
);
   localparam int CW = $clog2(MD_LATENCY + 1);
   if (MD_LATENCY < MD_LAT_MIN || MD_LATENCY > MD_LAT_MAX) begin : g_bad_latency
      $error("md_busy_timer: MD_LATENCY out of range 1..255");
   end
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (start) cnt <= CW'(MD_LATENCY);
      else if (cnt != '0) cnt <= cnt - CW'(1);
   assign busy = cnt != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding for the 5-stage pipeline with mul/div busy stall.
// Define HAZARD_PERF_EN to add saturating per-cause stall counters.
module hazard_ctrl import hazard_pkg::*; #(
   parameter int REG_AW      = 5,
   parameter int MD_LATENCY  = 32,
   parameter int STALL_CNT_W = 32
) (
   input  logic clk,
   input  logic rst,
   hazard_ctrl_if.slave h
`ifdef HAZARD_PERF_EN
   ,
   output logic [STALL_CNT_W-1:0] LwStallCnt,
   output logic [STALL_CNT_W-1:0] BrStallCnt,
   output logic [STALL_CNT_W-1:0] MdStallCnt
`endif
);
   localparam logic [REG_AW-1:0] Z = REG_AW'(REG_ZERO);
   if (STALL_CNT_W < 1) begin : g_bad_cnt_w
      $error("hazard_ctrl: STALL_CNT_W must be positive");
   end
   logic lwstall, brstall, mdstall, stall, md_busy;
   assign h.ForwardAE = fwd_sel(h.RsE != Z && h.RsE == h.WriteRegM && h.RegWriteM,
                                h.RsE != Z && h.RsE == h.WriteRegW && h.RegWriteW);
   assign h.ForwardBE = fwd_sel(h.RtE != Z && h.RtE == h.WriteRegM && h.RegWriteM,
                                h.RtE != Z && h.RtE == h.WriteRegW && h.RegWriteW);
   assign h.ForwardAD = h.RsD != Z && h.RsD == h.WriteRegM && h.RegWriteM;
   assign h.ForwardBD = h.RtD != Z && h.RtD == h.WriteRegM && h.RegWriteM;
   assign lwstall = h.MemtoRegE && h.RtE != Z && (h.RtE == h.RsD || h.RtE == h.RtD);
   // A branch compares in D, so an E producer or an M load cannot be forwarded in time.
   assign brstall = h.BranchD &&
      ((h.RegWriteE && h.WriteRegE != Z && (h.WriteRegE == h.RsD || h.WriteRegE == h.RtD)) ||
       (h.MemtoRegM && h.WriteRegM != Z && (h.WriteRegM == h.RsD || h.WriteRegM == h.RtD)));
   assign mdstall = h.MdOpD && md_busy;
   assign stall = lwstall | brstall | mdstall;
   assign h.StallF = stall;
   assign h.StallD = stall;
   assign h.FlushE = stall;
   assign h.MdBusy = md_busy;
   md_busy_timer #(.MD_LATENCY(MD_LATENCY)) u_md (
      .clk(clk), .rst(rst), .start(h.MdStartE), .busy(md_busy)
   );
`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         LwStallCnt <= '0;
         BrStallCnt <= '0;
         MdStallCnt <= '0;
      end else begin
         if (lwstall && !(&LwStallCnt)) LwStallCnt <= LwStallCnt + STALL_CNT_W'(1);
         if (brstall && !(&BrStallCnt)) BrStallCnt <= BrStallCnt + STALL_CNT_W'(1);
         if (mdstall && !(&MdStallCnt)) MdStallCnt <= MdStallCnt + STALL_CNT_W'(1);
      end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with MD_LATENCY=4.
module tb_hazard_ctrl;
   localparam int CW = 2;
   typedef logic [9:0] vec_t;
   logic clk, rst;
   vec_t q[$];
   int n_checks = 0, n_fail = 0;
   hazard_ctrl_if #(.REG_AW(5)) hif ();
`ifdef HAZARD_PERF_EN
   logic [CW-1:0] lw_cnt, br_cnt, md_cnt;
`endif
   hazard_ctrl #(.REG_AW(5), .MD_LATENCY(4), .STALL_CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .h(hif)
`ifdef HAZARD_PERF_EN
      , .LwStallCnt(lw_cnt), .BrStallCnt(br_cnt), .MdStallCnt(md_cnt)
`endif
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t ev(logic s, logic fad, logic fbd, logic [1:0] fae, logic [1:0] fbe, logic b);
      return {s, s, s, fad, fbd, fae, fbe, b};
   endfunction
   function automatic vec_t obs();
      return {hif.StallF, hif.StallD, hif.FlushE, hif.ForwardAD, hif.ForwardBD,
              hif.ForwardAE, hif.ForwardBE, hif.MdBusy};
   endfunction
   task automatic clr();
      {hif.BranchD, hif.MdOpD, hif.MemtoRegE, hif.RegWriteE, hif.MdStartE,
       hif.MemtoRegM, hif.RegWriteM, hif.RegWriteW} = '0;
      {hif.RsD, hif.RtD, hif.RsE, hif.RtE, hif.WriteRegE, hif.WriteRegM, hif.WriteRegW} = '0;
   endtask

   task automatic test_reset();
      vec_t e, got;
      rst = 1'b1;
      clr();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (i == 1) rst = 1'b0;
         q.push_back('0);
         #2;
         got = obs();
         e = q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset[%0d] got %b exp %b", i, got, e);
         end
      end
   endtask

   task automatic test_forward();
      vec_t e, got;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         clr();
         case (i)
            0: begin
               {hif.RsE, hif.RtE, hif.WriteRegM, hif.WriteRegW} = {5'd3, 5'd3, 5'd3, 5'd3};
               {hif.RegWriteM, hif.RegWriteW} = 2'b11;
               q.push_back(ev(0, 0, 0, 2'b10, 2'b10, 0));
            end
            1: begin
               {hif.RsE, hif.RtE, hif.WriteRegM, hif.WriteRegW} = {5'd3, 5'd3, 5'd3, 5'd3};
               hif.RegWriteW = 1'b1;
               q.push_back(ev(0, 0, 0, 2'b01, 2'b01, 0));
            end
            2: begin
               {hif.RtE, hif.WriteRegM, hif.WriteRegW} = {5'd3, 5'd3, 5'd3};
               hif.RegWriteW = 1'b1;
               q.push_back(ev(0, 0, 0, 2'b00, 2'b01, 0));
            end
            3: begin
               {hif.RegWriteM, hif.RegWriteW} = 2'b11;
               q.push_back(ev(0, 0, 0, 2'b00, 2'b00, 0));
            end
            4: begin
               {hif.RsD, hif.RtD, hif.WriteRegM} = {5'd3, 5'd5, 5'd3};
               hif.RegWriteM = 1'b1;
               q.push_back(ev(0, 1, 0, 2'b00, 2'b00, 0));
            end
            default: begin
               {hif.RtD, hif.WriteRegM, hif.RsE, hif.WriteRegW} = {5'd9, 5'd9, 5'd7, 5'd7};
               {hif.RegWriteM, hif.RegWriteW} = 2'b11;
               q.push_back(ev(0, 0, 1, 2'b01, 2'b00, 0));
            end
         endcase
         #2;
         got = obs();
         e = q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL forward[%0d] got %b exp %b", i, got, e);
         end
      end
   endtask

   task automatic test_load_use();
      vec_t e, got;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         clr();
         hif.MemtoRegE = (i != 3);
         hif.RtE = (i == 1) ? 5'd0 : 5'd8;
         if (i == 2) hif.RtD = 5'd8;
         else hif.RsD = 5'd8;
         q.push_back(ev(i == 0 || i == 2, 0, 0, 2'b00, 2'b00, 0));
         #2;
         got = obs();
         e = q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL load_use[%0d] got %b exp %b", i, got, e);
         end
      end
   endtask

   task automatic test_branch();
      vec_t e, got;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         clr();
         hif.BranchD = (i != 4);
         case (i)
            0: begin
               {hif.RegWriteE, hif.WriteRegE, hif.RtD} = {1'b1, 5'd4, 5'd4};
               q.push_back(ev(1, 0, 0, 2'b00, 2'b00, 0));
            end
            1: begin
               {hif.RegWriteM, hif.WriteRegM, hif.RtD} = {1'b1, 5'd4, 5'd4};
               q.push_back(ev(0, 0, 1, 2'b00, 2'b00, 0));
            end
            2: begin
               {hif.MemtoRegM, hif.RegWriteM, hif.WriteRegM, hif.RsD} = {2'b11, 5'd4, 5'd4};
               q.push_back(ev(1, 1, 0, 2'b00, 2'b00, 0));
            end
            3: begin
               hif.RegWriteE = 1'b1;
               q.push_back(ev(0, 0, 0, 2'b00, 2'b00, 0));
            end
            default: begin
               {hif.RegWriteE, hif.WriteRegE, hif.RsD} = {1'b1, 5'd4, 5'd4};
               q.push_back(ev(0, 0, 0, 2'b00, 2'b00, 0));
            end
         endcase
         #2;
         got = obs();
         e = q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL branch[%0d] got %b exp %b", i, got, e);
         end
      end
   endtask

   task automatic test_muldiv();
      vec_t e, got;
      logic busy, mdop;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         clr();
         mdop = (i <= 5);
         busy = (i >= 1 && i <= 4) || (i >= 7 && i <= 14);
         hif.MdOpD = mdop;
         hif.MdStartE = (i == 0 || i == 6 || i == 10);
         q.push_back(ev(mdop && busy, 0, 0, 2'b00, 2'b00, busy));
         #2;
         got = obs();
         e = q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL muldiv[%0d] got %b exp %b", i, got, e);
         end
      end
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf();
      vec_t e, got;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i != 1) begin
            rst = 1'b1;
            #1 rst = 1'b0;
            clr();
            {hif.MemtoRegE, hif.RtE, hif.RsD} = {1'b1, 5'd8, 5'd8};
            if (i == 2) {hif.BranchD, hif.RegWriteE, hif.WriteRegE} = {2'b11, 5'd8};
            @(negedge clk);
         end else repeat (4) @(negedge clk);
         q.push_back(vec_t'(i == 1 ? {2'd3, 2'd0, 2'd0} : {2'd1, 2'(i == 2), 2'd0}));
         #2;
         got = vec_t'({lw_cnt, br_cnt, md_cnt});
         e = q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL perf[%0d] got %b exp %b", i, got, e);
         end
      end
      clr();
   endtask
`endif

   task automatic test_reset_mid();
      vec_t e, got;
      @(negedge clk);
      clr();
      hif.MdStartE = 1'b1;
      @(negedge clk);
      clr();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (i == 1) rst = 1'b1;
         q.push_back(ev(0, 0, 0, 2'b00, 2'b00, i == 0));
         #1;
         got = obs();
         e = q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset_mid[%0d] got %b exp %b", i, got, e);
         end
      end
`ifdef HAZARD_PERF_EN
      q.push_back('0);
      got = vec_t'({lw_cnt, br_cnt, md_cnt});
      e = q.pop_front();
      n_checks++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL reset_mid_perf got %b exp %b", got, e);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_muldiv();
`ifdef HAZARD_PERF_EN
      test_perf();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
